// File: rtl/seg7_scan_ctrl_if.sv
// CPU write port and display pin bundle for the 4-digit 7-segment scan controller.
interface seg7_scan_ctrl_if;
  logic        wr_stb;
  logic        wr_sel;
  logic [15:0] wr_data;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic        frame_tick;
  logic        upd_pending;

  modport master (
    output wr_stb, wr_sel, wr_data,
    input  abcdefgh, digit, frame_tick, upd_pending
  );

  modport slave (
    input  wr_stb, wr_sel, wr_data,
    output abcdefgh, digit, frame_tick, upd_pending
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment scan controller: guarded round-robin multiplexing, PWM brightness and
// shadow registers that are copied to the active set only at the frame boundary.
module seg7_scan_ctrl #(
  parameter int unsigned PHASE_CYC = 6250
) (
  input logic             clk,
  input logic             resetb,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned PW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PHASE_CYC - 1);
  localparam logic [15:0] CTL_RST = 16'h07F0;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    phase_q, phase_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   hex_sh_q, hex_sh_d, hex_act_q, hex_act_d;
  logic [15:0]   ctl_sh_q, ctl_sh_d, ctl_act_q, ctl_act_d;
  logic          frame_start;
  logic          pend_d, pend_q;
  logic          tick_q;
  logic [7:0]    seg_d, seg_q;
  logic [3:0]    digit_d, digit_q;
  logic [6:0]    seg7;
  logic [3:0]    nib, en_vec, dp_vec;
  logic          lit;

  always_comb begin
    pcnt_d  = pcnt_q + 1'b1;
    phase_d = phase_q;
    dig_d   = dig_q;
    if (pcnt_q == PCNT_MAX) begin
      pcnt_d  = '0;
      phase_d = phase_q + 3'd1;
      if (phase_q == 3'd7) dig_d = dig_q + 2'd1;
    end
    frame_start = (pcnt_q == PCNT_MAX) && (phase_q == 3'd7) && (dig_q == 2'd3);

    // Active set takes the pre-edge shadow, so a write on the boundary waits a frame.
    hex_act_d = frame_start ? hex_sh_q : hex_act_q;
    ctl_act_d = frame_start ? ctl_sh_q : ctl_act_q;
    hex_sh_d  = hex_sh_q;
    ctl_sh_d  = ctl_sh_q;
    if (bus.wr_stb) begin
      if (bus.wr_sel) ctl_sh_d = {5'b0, bus.wr_data[10:0]};
      else            hex_sh_d = bus.wr_data;
    end
    pend_d = (hex_sh_d != hex_act_d) || (ctl_sh_d != ctl_act_d);
  end

  always_comb begin
    nib    = hex_act_q[{dig_q, 2'b00} +: 4];
    en_vec = ctl_act_q[7:4];
    dp_vec = ctl_act_q[3:0];
    case (nib)
      4'h0:    seg7 = 7'h7E;
      4'h1:    seg7 = 7'h30;
      4'h2:    seg7 = 7'h6D;
      4'h3:    seg7 = 7'h79;
      4'h4:    seg7 = 7'h33;
      4'h5:    seg7 = 7'h5B;
      4'h6:    seg7 = 7'h5F;
      4'h7:    seg7 = 7'h70;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h7B;
      4'hA:    seg7 = 7'h77;
      4'hB:    seg7 = 7'h1F;
      4'hC:    seg7 = 7'h4E;
      4'hD:    seg7 = 7'h3D;
      4'hE:    seg7 = 7'h4F;
      default: seg7 = 7'h47;
    endcase
    // Phase 0 is the anti-ghosting guard; the segment bus still follows the digit.
    lit     = (phase_q != 3'd0) && (phase_q <= ctl_act_q[10:8]) && en_vec[dig_q];
    seg_d   = ~{seg7, dp_vec[dig_q]};
    digit_d = lit ? ~(4'b0001 << dig_q) : 4'hF;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pcnt_q    <= '0;
      phase_q   <= 3'd0;
      dig_q     <= 2'd0;
      hex_sh_q  <= 16'h0000;
      hex_act_q <= 16'h0000;
      ctl_sh_q  <= CTL_RST;
      ctl_act_q <= CTL_RST;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      seg_q     <= 8'hFF;
      digit_q   <= 4'hF;
    end else begin
      pcnt_q    <= pcnt_d;
      phase_q   <= phase_d;
      dig_q     <= dig_d;
      hex_sh_q  <= hex_sh_d;
      hex_act_q <= hex_act_d;
      ctl_sh_q  <= ctl_sh_d;
      ctl_act_q <= ctl_act_d;
      pend_q    <= pend_d;
      tick_q    <= frame_start;
      seg_q     <= seg_d;
      digit_q   <= digit_d;
    end
  end

  assign bus.abcdefgh    = seg_q;
  assign bus.digit       = digit_q;
  assign bus.frame_tick  = tick_q;
  assign bus.upd_pending = pend_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-indexed display model queues the expected pins
// for every clock, and a negedge monitor pops and compares them against the DUT.
module tb_seg7_scan_ctrl;

  localparam int unsigned P     = 4;
  localparam int unsigned FRAME = 32 * P;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       tick;
    logic       pend;
  } exp_t;

  logic clk = 1'b0;
  logic resetb;
  int   total = 0;
  int   bad   = 0;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.PHASE_CYC(P)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [6:0]  seg_tab [16];
  int unsigned t;
  logic [15:0] m_hex_sh, m_hex_act, m_ctl_sh, m_ctl_act;
  exp_t        q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", name, t, got, want);
    end
  endtask

  // Reference model: display state is a pure function of edges since reset.
  initial begin
    int unsigned ph, d;
    logic [3:0]  nib;
    logic        lit;
    exp_t        e;
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    t = 0;
    m_hex_sh = 16'h0; m_hex_act = 16'h0; m_ctl_sh = 16'h07F0; m_ctl_act = 16'h07F0;
    forever begin
      @(posedge clk or negedge resetb);
      if (!resetb) begin
        t = 0;
        m_hex_sh = 16'h0; m_hex_act = 16'h0; m_ctl_sh = 16'h07F0; m_ctl_act = 16'h07F0;
        q.delete();
      end else begin
        ph    = (t / P) % 8;
        d     = (t / (8 * P)) % 4;
        nib   = m_hex_act[4*d +: 4];
        lit   = (ph != 0) && (ph <= int'(m_ctl_act[10:8])) && m_ctl_act[4+d];
        e.seg = ~{seg_tab[nib], m_ctl_act[d]};
        e.dig = lit ? ~(4'b0001 << d) : 4'hF;
        t++;
        e.tick = (t % FRAME) == 0;
        if (e.tick) begin
          m_hex_act = m_hex_sh;
          m_ctl_act = m_ctl_sh;
        end
        if (bus.wr_stb) begin
          if (bus.wr_sel) m_ctl_sh = {5'b0, bus.wr_data[10:0]};
          else            m_hex_sh = bus.wr_data;
        end
        e.pend = (m_hex_sh != m_hex_act) || (m_ctl_sh != m_ctl_act);
        q.push_back(e);
      end
    end
  end

  // Monitor: scoreboard pop plus structural checks on the digit pins.
  initial begin
    exp_t e;
    int   mc, last_tick, last_dig, gap, idx;
    mc = 0; last_tick = -1; last_dig = -1; gap = 0;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        chk("reset_pins", {18'b0, bus.abcdefgh, bus.digit, bus.frame_tick, bus.upd_pending},
            {18'b0, 8'hFF, 4'hF, 1'b0, 1'b0});
        mc = 0; last_tick = -1; last_dig = -1; gap = 0;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        mc++;
        chk("pins", {18'b0, bus.abcdefgh, bus.digit, bus.frame_tick, bus.upd_pending},
            {18'b0, e});
        chk("one_digit", {31'b0, $countones(~bus.digit) <= 1}, 32'd1);
        if (bus.frame_tick) begin
          if (last_tick >= 0) chk("tick_period", mc - last_tick, FRAME);
          last_tick = mc;
        end
        if (bus.digit == 4'hF) gap++;
        else begin
          idx = 0;
          for (int k = 0; k < 4; k++) if (!bus.digit[k]) idx = k;
          if (last_dig >= 0 && idx != last_dig) chk("guard_gap", {31'b0, gap >= int'(P)}, 32'd1);
          last_dig = idx;
          gap = 0;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic sel, input logic [15:0] data);
    @(negedge clk);
    bus.wr_stb = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
    @(negedge clk);
    bus.wr_stb = 1'b0;
  endtask

  initial begin
    logic        sel;
    logic [15:0] data;
    resetb = 1'b0;
    bus.wr_stb = 1'b0; bus.wr_sel = 1'b0; bus.wr_data = 16'h0;
    repeat (3) @(negedge clk);
    #1 resetb = 1'b1;
    wait_cyc(FRAME + 10);

    // Tear-free hex update mid-frame.
    do_write(1'b0, 16'h1234);
    wait_cyc(2 * FRAME);

    // Write landing exactly on the boundary edge.
    while ((t % FRAME) != FRAME - 1) @(negedge clk);
    bus.wr_stb = 1'b1; bus.wr_sel = 1'b0; bus.wr_data = 16'hFFFF;
    @(negedge clk);
    bus.wr_stb = 1'b0;
    wait_cyc(2 * FRAME + 5);

    // Brightness / enable / dp patterns.
    do_write(1'b1, 16'h02A5);
    wait_cyc(2 * FRAME);
    do_write(1'b1, 16'h00F0);
    wait_cyc(2 * FRAME);
    do_write(1'b1, 16'hFFFF);
    wait_cyc(2 * FRAME);

    // Random writes, some equal to the active value.
    for (int i = 0; i < 30; i++) begin
      sel  = 1'($urandom_range(1));
      data = 16'($urandom);
      if ($urandom_range(3) == 0) data = sel ? m_ctl_act : m_hex_act;
      do_write(sel, data);
      wait_cyc($urandom_range(60));
    end
    wait_cyc(2 * FRAME);

    // Async reset mid-frame, after a write.
    do_write(1'b0, 16'hBEEF);
    while ((t % FRAME) != 70) @(negedge clk);
    @(posedge clk);
    #2 resetb = 1'b0;
    #1;
    chk("async_seg", {24'b0, bus.abcdefgh}, 32'hFF);
    chk("async_digit", {28'b0, bus.digit}, 32'hF);
    chk("async_tick", {31'b0, bus.frame_tick}, 32'd0);
    chk("async_pend", {31'b0, bus.upd_pending}, 32'd0);
    repeat (2) @(negedge clk);
    #1 resetb = 1'b1;
    wait_cyc(2 * FRAME + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0d got=timeout want=finish", t);
    $fatal(1, "timeout");
  end

endmodule
